// File: rtl/pcie_descrambler.sv
// pcie_descrambler
// ----------------
// Descrambler for a 4-byte-wide 8b/10b symbol stream. It uses a 16-bit Galois
// LFSR (x^16+x^5+x^4+x^3+1). Within one cycle the valid bytes 0..data_len_i are
// walked oldest-first. Each byte does one of the following:
//   - COM (K, COM_SYM)    : passes through, then the LFSR is re-seeded to SEED
//   - SKP (K, SKP_SYM)    : passes through, the LFSR is frozen
//   - other K / TS byte   : passes through, the LFSR advances 8 times
//   - D byte              : XOR with the key bits, the LFSR advances 8 times
// Bytes above data_len_i pass through untouched and do not move the LFSR.
// All outputs are registered, so the latency is one cycle.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   valid_i               input word present this cycle
//   indata_i[31:0]        scrambled symbols, byte n at [8n+7:8n], byte 0 oldest
//   datak_i[3:0]          per-byte K flag
//   training_sequence_i   per-byte TS1/TS2 flag (byte is never descrambled)
//   data_len_i[1:0]       number of valid bytes minus one
//   descramble_enable_i   0 = data passes through, LFSR rules still apply
//   valid_o               output word valid
//   descrambled_data_o    recovered data, same byte mapping as the input
//   datak_o, data_len_o   registered copies of datak_i / data_len_i
//   locked_o              a COM has been seen since reset (lock FSM state)
//
// Handshake: valid-only. A word is consumed in every cycle where valid_i=1.
// There is no back-pressure. valid_o is valid_i delayed by one cycle. When a
// cycle has no valid word, the data outputs hold their last value.

module pcie_descrambler #(
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter logic [7:0]  COM_SYM = 8'hBC,
    parameter logic [7:0]  SKP_SYM = 8'h1C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] indata_i,
    input  logic [3:0]  datak_i,
    input  logic [3:0]  training_sequence_i,
    input  logic [1:0]  data_len_i,
    input  logic        descramble_enable_i,
    output logic        valid_o,
    output logic [31:0] descrambled_data_o,
    output logic [3:0]  datak_o,
    output logic [1:0]  data_len_o,
    output logic        locked_o
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t state_q, state_d;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [31:0] data_d;
    logic        com_seen;
    logic [7:0]  sym;

    // One Galois advance of x^16+x^5+x^4+x^3+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    endfunction

    // Serial walk over the word. Each byte sees the LFSR state left by the
    // byte before it, so a COM in the middle re-seeds only the bytes after it.
    always_comb begin
        lfsr_d   = lfsr_q;
        data_d   = indata_i;
        com_seen = 1'b0;
        sym      = 8'h00;
        for (int n = 0; n < 4; n++) begin
            sym = indata_i[8*n +: 8];
            if (2'(n) <= data_len_i) begin
                if (datak_i[n] && (sym == COM_SYM)) begin
                    lfsr_d   = SEED;
                    com_seen = 1'b1;
                end else if (datak_i[n] && (sym == SKP_SYM)) begin
                    lfsr_d = lfsr_d;
                end else if (datak_i[n] || training_sequence_i[n]) begin
                    for (int b = 0; b < 8; b++) begin
                        lfsr_d = lfsr_step(lfsr_d);
                    end
                end else begin
                    // Bit b (LSB first) uses lfsr[15] before the b-th advance.
                    for (int b = 0; b < 8; b++) begin
                        if (descramble_enable_i) begin
                            data_d[8*n + b] = indata_i[8*n + b] ^ lfsr_d[15];
                        end
                        lfsr_d = lfsr_step(lfsr_d);
                    end
                end
            end
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock FSM: next state. LOCKED is sticky until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (valid_i && com_seen) state_d = LOCKED;
            LOCKED:   state_d = LOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    // Lock FSM: output
    always_comb begin
        locked_o = (state_q == LOCKED);
    end

    // Datapath registers. The LFSR and the data outputs only move on valid words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q             <= SEED;
            valid_o            <= 1'b0;
            descrambled_data_o <= 32'h0;
            datak_o            <= 4'h0;
            data_len_o         <= 2'h0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                lfsr_q             <= lfsr_d;
                descrambled_data_o <= data_d;
                datak_o            <= datak_i;
                data_len_o         <= data_len_i;
            end
        end
    end

endmodule

// File: tb/tb_pcie_descrambler.sv
// Bench for pcie_descrambler.
// Key bytes from SEED 16'hFFFF are: 0xFF, 0x17, 0xC0, 0x14, 0xB2, ...
// Every driven cycle pushes one expected output record to exp_q:
//   {valid_o, locked_o, data_len_o, datak_o, descrambled_data_o}
// The monitor pops and compares one record at each falling edge.

module tb_pcie_descrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] indata_i = 32'h0;
    logic [3:0]  datak_i = 4'h0;
    logic [3:0]  ts_i = 4'h0;
    logic [1:0]  len_i = 2'h0;
    logic        en_i = 1'b1;
    logic        valid_o;
    logic [31:0] data_o;
    logic [3:0]  datak_o;
    logic [1:0]  len_o;
    logic        locked_o;

    pcie_descrambler dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .valid_i             (valid_i),
        .indata_i            (indata_i),
        .datak_i             (datak_i),
        .training_sequence_i (ts_i),
        .data_len_i          (len_i),
        .descramble_enable_i (en_i),
        .valid_o             (valid_o),
        .descrambled_data_o  (data_o),
        .datak_o             (datak_o),
        .data_len_o          (len_o),
        .locked_o            (locked_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          sb_idx   = 0;
    logic        sb_on    = 1'b0;
    logic [31:0] last_d   = 32'h0;
    logic [3:0]  last_k   = 4'h0;
    logic [1:0]  last_len = 2'h0;

    function automatic logic [39:0] outs();
        return {valid_o, locked_o, len_o, datak_o, data_o};
    endfunction

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one record per driven cycle.
    always @(negedge clk) begin
        logic [39:0] e;
        if (sb_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (outs() !== e) begin
                n_fail++;
                $display("FAIL sb[%0d] got %h expected %h", sb_idx, outs(), e);
            end
            sb_idx++;
        end
    end

    // driver
    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic [3:0] ts, input logic [1:0] len, input logic en,
                         input logic [31:0] exp_d, input logic exp_lock);
        @(negedge clk);
        #1;
        valid_i  = v;
        indata_i = d;
        datak_i  = k;
        ts_i     = ts;
        len_i    = len;
        en_i     = en;
        if (v) begin
            last_d   = exp_d;
            last_k   = k;
            last_len = len;
            exp_q.push_back({1'b1, exp_lock, len, k, exp_d});
        end else begin
            exp_q.push_back({1'b0, exp_lock, last_len, last_k, last_d});
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  ts;
        logic [1:0]  len;
        logic        en;
        logic [31:0] exp_d;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // v, data, datak, ts, len, en, expected data, expected locked
        vecs[0]  = '{1'b1, 32'h14C017FF, 4'b0000, 4'b0000, 2'd3, 1'b1, 32'h00000000, 1'b0}; // unlocked, from SEED
        vecs[1]  = '{1'b1, 32'h123456BC, 4'b0001, 4'b0000, 2'd0, 1'b1, 32'h123456BC, 1'b1}; // COM last valid byte
        vecs[2]  = '{1'b1, 32'hC0171CFF, 4'b0010, 4'b0000, 2'd3, 1'b1, 32'h00001C00, 1'b1}; // SKP freezes
        vecs[3]  = '{1'b1, 32'hAABBCC14, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'hAABBCC00, 1'b1}; // key 0x14, upper bytes kept
        vecs[4]  = '{1'b1, 32'h000000E8, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h0000005A, 1'b1}; // key 0xB2
        vecs[5]  = '{1'b1, 32'h4A4A4ABC, 4'b0001, 4'b1110, 2'd3, 1'b1, 32'h4A4A4ABC, 1'b1}; // COM + TS bytes
        vecs[6]  = '{1'b1, 32'h00000014, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h00000000, 1'b1}; // key index 3 after TS
        vecs[7]  = '{1'b1, 32'hFFBCFFBC, 4'b0101, 4'b0000, 2'd3, 1'b1, 32'h00BC00BC, 1'b1}; // two COMs
        vecs[8]  = '{1'b1, 32'hB214FC17, 4'b0010, 4'b0000, 2'd3, 1'b1, 32'h0000FC00, 1'b1}; // other K advances
        vecs[9]  = '{1'b1, 32'h4433FFBC, 4'b0001, 4'b0000, 2'd1, 1'b1, 32'h443300BC, 1'b1}; // partial length
        vecs[10] = '{1'b1, 32'h0000005A, 4'b0000, 4'b0000, 2'd0, 1'b0, 32'h0000005A, 1'b1}; // disabled
        vecs[11] = '{1'b1, 32'h000000C0, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h00000000, 1'b1}; // re-enabled, key index 2
        vecs[12] = '{1'b0, 32'hDEADBEEF, 4'b1111, 4'b0000, 2'd3, 1'b1, 32'h00000000, 1'b1}; // idle, hold

        // reset state
        repeat (3) @(negedge clk);
        check("reset_state", outs(), 40'h0);
        #3;
        rst   = 1'b0;
        sb_on = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].k, vecs[i].ts, vecs[i].len, vecs[i].en,
                  vecs[i].exp_d, vecs[i].exp_lock);
        end

        // Gap of five idle cycles between two D words: the key continues.
        drive(1'b1, 32'h0017FFBC, 4'b0001, 4'b0000, 2'd2, 1'b1, 32'h000000BC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, $urandom, 4'($urandom_range(0, 15)), 4'h0, 2'($urandom_range(0, 3)),
                  1'b1, 32'h0, 1'b1);
        end
        drive(1'b1, 32'h000014C0, 4'b0000, 4'b0000, 2'd1, 1'b1, 32'h00000000, 1'b1);

        // Asynchronous reset between edges with a word in flight.
        drive(1'b1, 32'h000000BC, 4'b0001, 4'b0000, 2'd0, 1'b1, 32'h000000BC, 1'b1);
        drive(1'b1, 32'h000000B2, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h00000000, 1'b1);
        #2;
        rst   = 1'b1;
        sb_on = 1'b0;
        exp_q.delete();
        last_d   = 32'h0;
        last_k   = 4'h0;
        last_len = 2'h0;
        #1;
        check("async_reset", outs(), 40'h0);
        valid_i = 1'b0;
        @(negedge clk);
        check("reset_held", outs(), 40'h0);
        #3;
        rst   = 1'b0;
        sb_on = 1'b1;
        drive(1'b1, 32'h000000FF, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h00000000, 1'b0);
        drive(1'b1, 32'h0000C017, 4'b0000, 4'b0000, 2'd1, 1'b1, 32'h00000000, 1'b0);
        drive(1'b0, 32'h0, 4'h0, 4'h0, 2'd0, 1'b1, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        check("drain", 40'(exp_q.size()), 40'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_descrambler.md
PCIE_DESCRAMBLER -- requirements
Module: pcie_descrambler

Interface
REQ-001 SHALL have parameter SEED, default 16'hFFFF, LFSR value loaded on reset and on every COM.
REQ-002 SHALL have parameter COM_SYM, default 8'hBC, K28.5 code that re-seeds the LFSR.
REQ-003 SHALL have parameter SKP_SYM, default 8'h1C, K28.0 code that freezes the LFSR.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port valid_i  input  1  the input word is present this cycle.
REQ-007 SHALL have port indata_i  input  32  scrambled symbols; byte n at bits [8n+7:8n]; byte 0 is oldest.
REQ-008 SHALL have port datak_i  input  4  per-byte K-symbol flag.
REQ-009 SHALL have port training_sequence_i  input  4  per-byte TS1/TS2 flag; the byte passes unscrambled.
REQ-010 SHALL have port data_len_i  input  2  valid bytes minus 1 (0 means byte 0 only; 3 means all four bytes).
REQ-011 SHALL have port descramble_enable_i  input  1  0 means all bytes pass through unchanged.
REQ-012 SHALL have port valid_o  output  1  the output word is valid.
REQ-013 SHALL have port descrambled_data_o  output  32  recovered data, same byte mapping as the input.
REQ-014 SHALL have port datak_o  output  4  registered copy of datak_i.
REQ-015 SHALL have port data_len_o  output  2  registered copy of data_len_i.
REQ-016 SHALL have port locked_o  output  1  a COM has been seen since reset.

Function
REQ-017 SHALL use a 16-bit Galois LFSR, polynomial x^16+x^5+x^4+x^3+1; one advance is next = {lfsr[14:0],1'b0} ^ (lfsr[15] ? 16'h0039 : 16'h0).
REQ-018 SHALL XOR data bit b (b = 0..7, LSB first) with lfsr[15] taken before the b-th of that byte's 8 advances.
REQ-019 SHALL process the valid bytes 0..data_len_i serially within one cycle; each byte sees the LFSR state left by the preceding byte in the same word.
REQ-020 SHALL handle a COM byte (datak=1, value COM_SYM) as follows: pass through unchanged, set the LFSR to SEED after the byte, and set locked_o.
REQ-021 SHALL handle a SKP byte (datak=1, value SKP_SYM) as follows: pass through unchanged and leave the LFSR unchanged.
REQ-022 SHALL handle any other K byte, or any byte with training_sequence_i set, as follows: pass through unchanged and advance the LFSR 8 times.
REQ-023 SHALL handle any other D byte as follows: descramble per REQ-018 and advance the LFSR 8 times.
REQ-024 SHALL, when descramble_enable_i=0, pass data through unchanged while still applying the COM, SKP and advance rules to the LFSR.
REQ-025 SHALL leave bytes above data_len_i unchanged in the output, with no effect on the LFSR.
REQ-026 SHALL register all outputs with a latency of exactly 1 cycle: valid_o(t+1) = valid_i(t).
REQ-027 SHALL, when valid_i=0, hold the LFSR and all data outputs and drive valid_o=0.
REQ-028 SHALL implement a lock state machine with states UNLOCKED and LOCKED.
REQ-029 SHALL move from UNLOCKED to LOCKED on any valid COM byte; LOCKED is left only by reset.
REQ-030 SHALL still descramble, starting from SEED, while UNLOCKED.
REQ-031 SHALL, when several COMs occur in one word, re-seed at each COM; the bytes that follow the last COM use SEED.
REQ-032 SHALL, when a COM is the last valid byte, leave the LFSR at SEED at the end of the cycle.

Reset
REQ-033 SHALL, while rst_i=1, force LFSR=SEED, locked_o=0, valid_o=0, descrambled_data_o=0, datak_o=0 and data_len_o=0 immediately, independent of clk_i.
REQ-034 SHALL, when reset is asserted mid-stream, discard the in-flight word; the first valid word after release uses SEED.

Verification
REQ-035 SHALL cover this case: COM byte followed by D bytes 0xFF, 0x17, 0xC0 in one word (len=3) -> output 0xBC, 0x00, 0x00, 0x00 one cycle later; locked_o=1.
REQ-036 SHALL cover this case: COM in word 0; word 1 = D bytes {0xFF, SKP, 0x17, 0xC0} with datak=4'b0010 -> data bytes 0x00, 0x1C, 0x00, 0x00.
REQ-037 SHALL cover this case: word with training_sequence_i=4'b1110 after COM -> bytes 1-3 unchanged; the next D byte is descrambled with key byte 4 (0x14).
REQ-038 SHALL cover this case: valid_i low for 5 cycles between two D words -> the key continues seamlessly; valid_o low for exactly those 5 cycles.
REQ-039 SHALL cover this case: rst_i pulsed asynchronously between clock edges mid-stream -> outputs zero at once; after release, input 0xFF (D) decodes to 0x00.
REQ-040 SHALL cover this case: descramble_enable_i=0 with input 0x5A -> output 0x5A; on re-enable the key position equals the number of bytes advanced.
